// File: rtl/drv_display_mux_if.sv
// Bundle of the display-mux control inputs and the registered digit/segment drive outputs.
// The master drives load/digits/options; the slave (the mux) drives enable/segmentos/frame_tick.
interface drv_display_mux_if #(
  parameter int N_DIG = 4
);
  logic                   load;
  logic [5*N_DIG-1:0]     digits;
  logic [N_DIG-1:0]       blink_mask;
  logic                   lzs;
  logic [2:0]             bright;
  logic [N_DIG-1:0]       enable;
  logic [6:0]             segmentos;
  logic                   frame_tick;

  modport master (
    output load, digits, blink_mask, lzs, bright,
    input  enable, segmentos, frame_tick
  );

  modport slave (
    input  load, digits, blink_mask, lzs, bright,
    output enable, segmentos, frame_tick
  );
endinterface

// File: rtl/drv_display_mux.sv
// Time-multiplexed 7-segment driver: one digit per slot, frame-synchronous digit update,
// leading-zero suppression, per-digit blink and PWM brightness on the digit enables.
module drv_display_mux #(
  parameter int N_DIG    = 4,
  parameter int DIV      = 1000,
  parameter int BLINK_FR = 64
) (
  input  logic             clk,
  input  logic             rst,
  drv_display_mux_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(N_DIG);
  localparam int FW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
  // Wide enough for (bright+1)*DIV and 8*cnt without truncation.
  localparam int DW = CW + 4;
  localparam logic [5*N_DIG-1:0] ALL_BLANK = {N_DIG{5'd16}};

  logic [CW-1:0]      cnt_reg;
  logic [IW-1:0]      idx_reg;
  logic [5*N_DIG-1:0] pending_reg;
  logic [5*N_DIG-1:0] active_reg;
  logic [FW-1:0]      frame_cnt_reg;
  logic               phase_reg;
  logic [N_DIG-1:0]   enable_reg;
  logic [6:0]         seg_reg;
  logic               tick_reg;

  logic               slot_end;
  logic               frame_end;
  logic [4:0]         code [N_DIG];
  logic [N_DIG-1:0]   quiet;
  logic [N_DIG-1:0]   suppress;
  logic               higher_quiet;
  logic               cur_blank;
  logic [DW-1:0]      duty_lhs;
  logic [DW-1:0]      duty_rhs;
  logic [N_DIG-1:0]   enable_next;
  logic [6:0]         seg_next;

  function automatic logic [6:0] seg_decode(input logic [4:0] c);
    case (c)
      5'd0:    seg_decode = 7'h3F;
      5'd1:    seg_decode = 7'h06;
      5'd2:    seg_decode = 7'h5B;
      5'd3:    seg_decode = 7'h4F;
      5'd4:    seg_decode = 7'h66;
      5'd5:    seg_decode = 7'h6D;
      5'd6:    seg_decode = 7'h7D;
      5'd7:    seg_decode = 7'h07;
      5'd8:    seg_decode = 7'h7F;
      5'd9:    seg_decode = 7'h6F;
      5'd10:   seg_decode = 7'h77;
      5'd11:   seg_decode = 7'h7C;
      5'd12:   seg_decode = 7'h39;
      5'd13:   seg_decode = 7'h5E;
      5'd14:   seg_decode = 7'h79;
      5'd15:   seg_decode = 7'h71;
      5'd17:   seg_decode = 7'h40;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  assign slot_end  = (cnt_reg == CW'(DIV - 1));
  assign frame_end = slot_end && (idx_reg == IW'(N_DIG - 1));

  for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
    assign code[gi]  = active_reg[5*gi +: 5];
    assign quiet[gi] = (code[gi] == 5'd0) || (code[gi] == 5'd16);
  end

  // Walk from the most significant digit down: a zero is suppressed only while
  // everything above it is still zero or blank.
  always_comb begin
    suppress     = '0;
    higher_quiet = 1'b1;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      suppress[k]  = bus.lzs && (k != 0) && (code[k] == 5'd0) && higher_quiet;
      higher_quiet = higher_quiet && quiet[k];
    end
  end

  assign cur_blank = suppress[idx_reg] || (phase_reg && bus.blink_mask[idx_reg]);
  assign seg_next  = cur_blank ? 7'h00 : seg_decode(code[idx_reg]);

  assign duty_lhs    = DW'(cnt_reg) << 3;
  assign duty_rhs    = (DW'(bus.bright) + DW'(1)) * DW'(DIV);
  assign enable_next = (duty_lhs < duty_rhs) ? (N_DIG'(1) << idx_reg) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      idx_reg       <= '0;
      pending_reg   <= ALL_BLANK;
      active_reg    <= ALL_BLANK;
      frame_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      enable_reg    <= '0;
      seg_reg       <= 7'h00;
      tick_reg      <= 1'b0;
    end else begin
      cnt_reg <= slot_end ? '0 : cnt_reg + CW'(1);
      if (slot_end)
        idx_reg <= (idx_reg == IW'(N_DIG - 1)) ? '0 : idx_reg + IW'(1);
      if (bus.load)
        pending_reg <= bus.digits;
      // A load landing exactly on the frame boundary bypasses pending so it is not lost.
      if (frame_end) begin
        active_reg <= bus.load ? bus.digits : pending_reg;
        if (frame_cnt_reg == FW'(BLINK_FR - 1)) begin
          frame_cnt_reg <= '0;
          phase_reg     <= ~phase_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + FW'(1);
        end
      end
      enable_reg <= enable_next;
      seg_reg    <= seg_next;
      tick_reg   <= frame_end;
    end
  end

  assign bus.enable     = enable_reg;
  assign bus.segmentos  = seg_reg;
  assign bus.frame_tick = tick_reg;
endmodule

// File: tb/tb_drv_display_mux.sv
// Bench for drv_display_mux: directed scenarios plus random traffic, every output cycle
// compared against a time-based reference model (slot/frame derived from cycles since reset).
module tb_drv_display_mux;
  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BF    = 2;
  localparam int FRAME = N * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drv_display_mux_if #(.N_DIG(N)) ifc();

  drv_display_mux #(.N_DIG(N), .DIV(DIV), .BLINK_FR(BF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int seg_tab [32];
  int t;
  int pend [N];
  int act  [N];
  int e_en, e_seg, e_ft;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
    end
  endtask

  function automatic logic [5*N-1:0] pack(input int d3, input int d2, input int d1, input int d0);
    return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  function automatic int rnd_code();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 16;
      2:       return 17;
      default: return int'($urandom_range(0, 31));
    endcase
  endfunction

  // One clock: predict outputs from model state and current inputs, advance the model,
  // then compare the DUT just after the edge.
  task automatic tick();
    int cnt, idx, fr, code;
    bit fe, ph, sup;
    int nd [N];
    if (rst) begin
      e_en = 0; e_seg = 0; e_ft = 0; t = 0;
      for (int k = 0; k < N; k++) begin pend[k] = 16; act[k] = 16; end
    end else begin
      cnt  = t % DIV;
      idx  = (t / DIV) % N;
      fr   = t / FRAME;
      fe   = (t % FRAME) == FRAME - 1;
      ph   = ((fr / BF) % 2) == 1;
      e_en = (8 * cnt < (int'(ifc.bright) + 1) * DIV) ? (1 << idx) : 0;
      code = act[idx];
      sup  = ifc.lzs && idx > 0 && code == 0;
      for (int j = idx + 1; j < N; j++)
        if (act[j] != 0 && act[j] != 16) sup = 0;
      e_seg = (sup || (ph && ifc.blink_mask[idx])) ? 0 : seg_tab[code];
      e_ft  = fe ? 1 : 0;
      for (int k = 0; k < N; k++) nd[k] = int'(ifc.digits[5*k +: 5]);
      if (fe) for (int k = 0; k < N; k++) act[k] = ifc.load ? nd[k] : pend[k];
      if (ifc.load) for (int k = 0; k < N; k++) pend[k] = nd[k];
      t++;
    end
    @(posedge clk);
    #1;
    check("enable", 32'(ifc.enable), e_en);
    check("segmentos", 32'(ifc.segmentos), e_seg);
    check("frame_tick", 32'(ifc.frame_tick), e_ft);
    check("onehot", ($countones(ifc.enable) <= 1) ? 1 : 0, 1);
  endtask

  task automatic go_to(input int pos);
    for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) tick();
  endtask

  task automatic load_once(input logic [5*N-1:0] d);
    ifc.digits = d;
    ifc.load   = 1'b1;
    tick();
    ifc.load   = 1'b0;
  endtask

  initial begin
    int seen06, cnt5b, cnt07;
    seg_tab = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71,
                'h00, 'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ifc.load = 1'b0; ifc.digits = '0; ifc.blink_mask = '0; ifc.lzs = 1'b0; ifc.bright = 3'd7;
    t = 0;

    // Reset overrides a concurrent load.
    rst = 1'b1;
    ifc.digits = pack(9, 9, 9, 9); ifc.load = 1'b1;
    repeat (3) tick();
    ifc.load = 1'b0;
    rst = 1'b0;

    // Basic frame: blank until the boundary, then 0,1,2,3.
    load_once(pack(3, 2, 1, 0));
    repeat (2 * FRAME) tick();

    // Leading-zero suppression on and off.
    load_once(pack(0, 0, 5, 0));
    ifc.lzs = 1'b1;
    repeat (2 * FRAME) tick();
    ifc.lzs = 1'b0;
    repeat (FRAME) tick();

    // Brightness duty.
    ifc.bright = 3'd0; repeat (FRAME) tick();
    ifc.bright = 3'd3; repeat (FRAME) tick();
    ifc.bright = 3'd7;

    // Last load in a frame wins; no mixed frame.
    go_to(5);  load_once(pack(1, 1, 1, 1));
    go_to(20); load_once(pack(2, 2, 2, 2));
    go_to(31); tick();
    seen06 = 0; cnt5b = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (ifc.segmentos == 7'h06) seen06++;
      if (ifc.segmentos == 7'h5B) cnt5b++;
    end
    check("no_mixed_06", seen06, 0);
    check("all_5b", cnt5b, FRAME);

    // Load coincident with frame_end shows in the following frame.
    go_to(31); load_once(pack(7, 7, 7, 7));
    cnt07 = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (ifc.segmentos == 7'h07) cnt07++;
    end
    check("edge_load_07", cnt07, FRAME);

    // Blink on digit 0.
    ifc.blink_mask = 4'b0001;
    load_once(pack(4, 3, 2, 1));
    repeat (6 * FRAME) tick();
    ifc.blink_mask = '0;

    // Reset mid-slot at idx 2 discards pending data.
    load_once(pack(8, 8, 8, 8));
    go_to(2 * DIV + 3);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (2 * FRAME) tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 6) begin
        ifc.digits = pack(rnd_code(), rnd_code(), rnd_code(), rnd_code());
        ifc.load   = 1'b1;
      end else begin
        ifc.load = 1'b0;
      end
      if ($urandom_range(0, 99) < 3) ifc.bright = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) ifc.blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) ifc.lzs = ~ifc.lzs;
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; ifc.load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
